// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: TX serialiser and RX deserialiser (2-flop synchronised input).
// Optional macro UART_TXRX_LOOPBACK_EN feeds the RX path from the TX line internally.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;

  state_t          r_tx_state;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_idx;
  logic [7:0]      r_tx_byte;

  state_t          r_rx_state;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_idx;
  logic [7:0]      r_rx_shift;
  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            w_rx_in;

`ifdef UART_TXRX_LOOPBACK_EN
  assign w_rx_in = o_TX_Active ? o_TX_Serial : 1'b1;
`else
  assign w_rx_in = i_RX_Serial;
`endif

  // Serial line is driven one bit ahead so each level lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_tx_state  <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_tx_byte   <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      case (r_tx_state)
        S_IDLE: begin
          o_TX_Serial <= 1'b1;
          r_tx_cnt    <= '0;
          r_tx_idx    <= '0;
          if (i_TX_DV) begin
            r_tx_byte   <= i_TX_Byte;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
            r_tx_state  <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt != C_LAST) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end else begin
            r_tx_cnt    <= '0;
            o_TX_Serial <= r_tx_byte[0];
            r_tx_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_tx_cnt != C_LAST) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end else begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx_idx    <= '0;
              o_TX_Serial <= 1'b1;
              r_tx_state  <= S_STOP;
            end else begin
              r_tx_idx    <= r_tx_idx + 3'd1;
              o_TX_Serial <= r_tx_byte[r_tx_idx + 3'd1];
            end
          end
        end
        S_STOP: begin
          if (r_tx_cnt != C_LAST) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end else begin
            r_tx_cnt    <= '0;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b1;
            r_tx_state  <= S_CLEANUP;
          end
        end
        S_CLEANUP: r_tx_state <= S_IDLE;
        default:   r_tx_state <= S_IDLE;
      endcase
    end
  end

  // Start bit is re-checked at its midpoint; later samples then land mid-bit.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
    end else begin
      r_rx_meta <= w_rx_in;
      r_rx_sync <= r_rx_meta;
      o_RX_DV   <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_idx <= '0;
          if (!r_rx_sync) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_rx_cnt == C_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt != C_LAST) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end else begin
            r_rx_cnt             <= '0;
            r_rx_shift[r_rx_idx] <= r_rx_sync;
            r_rx_idx             <= r_rx_idx + 3'd1;
            if (r_rx_idx == 3'd7) r_rx_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_rx_cnt != C_LAST) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end else begin
            r_rx_cnt <= '0;
            if (r_rx_sync) begin
              o_RX_Byte <= r_rx_shift;
              o_RX_DV   <= 1'b1;
            end
            r_rx_state <= S_CLEANUP;
          end
        end
        S_CLEANUP: r_rx_state <= S_IDLE;
        default:   r_rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed self-checking bench for uart_txrx: external loopback, back-to-back frames,
// ignored mid-frame strobe, glitch rejection, framing error and mid-frame reset.
module tb_uart_txrx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done, rx_dv;
  logic [7:0] rx_byte;
  logic       force_en, force_val;
  logic       rx_serial;

  always #5 clk = ~clk;

  assign rx_serial = force_en ? force_val : (tx_active ? tx_serial : 1'b1);

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Active(tx_active),
    .o_TX_Serial(tx_serial),
    .o_TX_Done  (tx_done),
    .i_RX_Serial(rx_serial),
    .o_RX_DV    (rx_dv),
    .o_RX_Byte  (rx_byte)
  );

  int         tests = 0;
  int         fails = 0;
  int         dv_count = 0;
  int         done_count = 0;
  logic [7:0] rx_q[$];
  int         start_run = 0;
  int         last_start_run = 0;
  bit         meas_on = 1'b0;
  logic       prev_active = 1'b0;

  // Observe outputs 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (rx_dv) begin
      dv_count++;
      rx_q.push_back(rx_byte);
    end
    if (tx_done) done_count++;
    if (tx_active && !prev_active) begin
      meas_on   = 1'b1;
      start_run = 0;
    end
    if (meas_on) begin
      if (!tx_serial) start_run++;
      else begin
        meas_on        = 1'b0;
        last_start_run = start_run;
      end
    end
    prev_active = tx_active;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_byte = b;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
  endtask

  task automatic wait_dv(input int target, input string tag);
    for (int i = 0; i < 600 && dv_count < target; i++) @(negedge clk);
    check(tag, dv_count, target);
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 600 && done_count < target; i++) @(negedge clk);
    check(tag, done_count, target);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    force_en  = 1'b1;
    force_val = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      force_val = b[i];
      tick(CPB);
    end
    force_val = stop;
    tick(CPB);
    force_val = 1'b1;
    tick(2 * CPB);
    force_en = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    tx_dv     = 1'b0;
    tx_byte   = 8'h00;
    force_en  = 1'b0;
    force_val = 1'b1;
    tick(3);
    check("rst_serial", tx_serial, 1);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    check("rst_rx_dv", rx_dv, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    rst = 1'b0;
    tick(2);

    // Single loopback frame
    send(8'h3F);
    wait_dv(1, "lb_dv_seen");
    check("lb_byte", rx_q[0], 8'h3F);
    wait_done(1, "lb_done_seen");
    tick(3 * CPB);
    check("lb_done_once", done_count, 1);
    check("lb_dv_once", dv_count, 1);

    // Back-to-back frames, next strobe one cycle after each done pulse
    send(8'h00);
    wait_done(2, "b2b_done0");
    tick(1);
    send(8'hFF);
    wait_done(3, "b2b_done1");
    tick(1);
    send(8'hA5);
    wait_done(4, "b2b_done2");
    tick(3 * CPB);
    check("b2b_dv_count", dv_count, 4);
    check("b2b_byte0", rx_q[1], 8'h00);
    check("b2b_byte1", rx_q[2], 8'hFF);
    check("b2b_byte2", rx_q[3], 8'hA5);
    check("start_bit_len", last_start_run, CPB);

    // Strobe during a frame is ignored
    send(8'h3F);
    tick(3 * CPB);
    send(8'h55);
    wait_done(5, "ign_done");
    tick(12 * CPB);
    check("ign_dv_count", dv_count, 5);
    check("ign_byte", rx_q[4], 8'h3F);
    check("ign_done_count", done_count, 5);
    check("ign_idle", tx_active, 0);

    // Short low glitch is rejected; a real frame afterwards is received
    force_en  = 1'b1;
    force_val = 1'b0;
    tick(CPB / 4);
    force_val = 1'b1;
    tick(3 * CPB);
    force_en = 1'b0;
    check("glitch_no_dv", dv_count, 5);
    send(8'hC3);
    wait_dv(6, "post_glitch_dv");
    check("post_glitch_byte", rx_q[5], 8'hC3);

    // Stop bit low: frame discarded
    tick(2 * CPB);
    drive_frame(8'h81, 1'b0);
    tick(CPB);
    check("frm_err_no_dv", dv_count, 6);
    check("frm_err_hold", rx_byte, 8'hC3);

    // Reset in the middle of the data bits
    send(8'hA5);
    tick(4 * CPB);
    rst = 1'b1;
    tick(1);
    check("midrst_serial", tx_serial, 1);
    check("midrst_active", tx_active, 0);
    check("midrst_rx_byte", rx_byte, 8'h00);
    rst = 1'b0;
    tick(2);
    send(8'h3C);
    wait_dv(7, "post_rst_dv");
    check("post_rst_byte", rx_q[6], 8'h3C);
    check("post_rst_out", rx_byte, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
